cic_decim_iq: RTL and testbench

Dual-channel (I/Q) CIC decimation filter directly downstream of the 2-bit RF mixer. It takes the mixer's BITS-wide signed I/Q products at full CLK rate, runs STAGES integrators at CLK rate, and decimates by R = 2^LOG2_R. It applies STAGES comb sections at the decimated rate and emits truncated OUT_BITS-wide I/Q samples with a one-cycle valid strobe for the following FIR/demodulator stage.

---
 rtl/cic_decim_iq.sv | 106 ++++++++++
 tb/tb_cic_decim_iq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_iq.sv
// Dual-channel (I/Q) CIC decimator: STAGES integrators at CLK rate,
// decimate by 2^LOG2_R, STAGES combs, MSB-truncated OUT_BITS outputs.
// Ports: CLK, RSTb (async, active-low), I_in/Q_in (signed BITS),
//        I_out/Q_out (signed OUT_BITS), out_valid (one-cycle strobe).
module cic_decim_iq #(
  parameter int BITS     = 6,
  parameter int STAGES   = 3,
  parameter int LOG2_R   = 6,
  parameter int OUT_BITS = 16
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic signed [BITS-1:0]     I_in,
  input  logic signed [BITS-1:0]     Q_in,
  output logic signed [OUT_BITS-1:0] I_out,
  output logic signed [OUT_BITS-1:0] Q_out,
  output logic                       out_valid
);

  localparam int ACC = BITS + STAGES * LOG2_R;
  localparam int SH  = ACC - OUT_BITS;

  typedef logic signed [ACC-1:0] acc_t;

  acc_t i_x, q_x;
  acc_t i_int [STAGES];
  acc_t q_int [STAGES];
  acc_t i_c   [STAGES+1];
  acc_t q_c   [STAGES+1];
  acc_t i_d   [STAGES];
  acc_t q_d   [STAGES];

  logic [LOG2_R-1:0] cnt;
  logic [STAGES:0]   v;
  logic              strobe;

  assign i_x = {{(ACC-BITS){I_in[BITS-1]}}, I_in};
  assign q_x = {{(ACC-BITS){Q_in[BITS-1]}}, Q_in};

  assign strobe = (cnt == '1);

  // Integrators wrap modulo 2^ACC; the comb differences undo the wrap.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      cnt <= '0;
      for (int k = 0; k < STAGES; k++) begin
        i_int[k] <= '0;
        q_int[k] <= '0;
      end
    end else begin
      cnt      <= cnt + LOG2_R'(1);
      i_int[0] <= i_int[0] + i_x;
      q_int[0] <= q_int[0] + q_x;
      for (int k = 1; k < STAGES; k++) begin
        i_int[k] <= i_int[k] + i_int[k-1];
        q_int[k] <= q_int[k] + q_int[k-1];
      end
    end
  end

  // Comb pipeline advances one stage per cycle behind the valid token.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      v <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        i_c[k] <= '0;
        q_c[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        i_d[k] <= '0;
        q_d[k] <= '0;
      end
    end else begin
      v[0] <= strobe;
      if (strobe) begin
        i_c[0] <= i_int[STAGES-1];
        q_c[0] <= q_int[STAGES-1];
      end
      for (int k = 1; k <= STAGES; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) begin
          i_c[k]   <= i_c[k-1] - i_d[k-1];
          q_c[k]   <= q_c[k-1] - q_d[k-1];
          i_d[k-1] <= i_c[k-1];
          q_d[k-1] <= q_c[k-1];
        end
      end
    end
  end

  // Keep the top OUT_BITS of the comb result; low bits are dropped.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      I_out     <= '0;
      Q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v[STAGES];
      if (v[STAGES]) begin
        I_out <= OUT_BITS'(i_c[STAGES] >>> SH);
        Q_out <= OUT_BITS'(q_c[STAGES] >>> SH);
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_iq.sv
// Scoreboard bench for cic_decim_iq: three instances (defaults,
// full-precision output, STAGES=1/R=16) driven by directed vectors.
module tb_cic_decim_iq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra = 1'b0;
  logic rb = 1'b0;
  logic rc = 1'b0;

  logic signed [5:0]  ia_in = '0;
  logic signed [5:0]  qa_in = '0;
  logic signed [5:0]  ib_in = '0;
  logic signed [5:0]  qb_in = '0;
  logic signed [5:0]  ic_in = '0;
  logic signed [5:0]  qc_in = '0;
  logic signed [15:0] ia, qa;
  logic signed [23:0] ib, qb;
  logic signed [9:0]  ic, qc;
  logic               va, vb, vc;

  cic_decim_iq dut_a (
    .CLK(clk), .RSTb(ra), .I_in(ia_in), .Q_in(qa_in),
    .I_out(ia), .Q_out(qa), .out_valid(va)
  );

  cic_decim_iq #(.OUT_BITS(24)) dut_b (
    .CLK(clk), .RSTb(rb), .I_in(ib_in), .Q_in(qb_in),
    .I_out(ib), .Q_out(qb), .out_valid(vb)
  );

  cic_decim_iq #(.STAGES(1), .LOG2_R(4), .OUT_BITS(10)) dut_c (
    .CLK(clk), .RSTb(rc), .I_in(ic_in), .Q_in(qc_in),
    .I_out(ic), .Q_out(qc), .out_valid(vc)
  );

  typedef struct {
    int cyc;
    bit chk;
    int i;
    int q;
  } exp_t;

  exp_t qa_exp[$];
  exp_t qc_exp[$];

  int total = 0;
  int bad   = 0;
  int cyc_a = 0;
  int cyc_c = 0;
  int b_sum = 0;
  int b_qsum = 0;
  int b_cnt = 0;

  // Rising edges since the last reset release.
  always @(posedge clk or negedge ra)
    if (!ra) cyc_a <= 0;
    else     cyc_a <= cyc_a + 1;

  always @(posedge clk or negedge rc)
    if (!rc) cyc_c <= 0;
    else     cyc_c <= cyc_c + 1;

  task automatic check(input string nm, input int act,
                       input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Output m appears after edge r*m + s + 1; outputs before `first`
  // are start-up transients and only their timing is checked.
  task automatic expect_run(input bit to_c, input int n,
                            input int r, input int s,
                            input int first, input int i,
                            input int q);
    for (int m = 1; r * m + s + 1 <= n; m++) begin
      exp_t e;
      e = '{cyc: r * m + s + 1, chk: (m >= first), i: i, q: q};
      if (to_c) qc_exp.push_back(e);
      else      qa_exp.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (va === 1'b1) begin
      if (qa_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra: valid at cycle %0d want none",
                 cyc_a);
      end else begin
        e = qa_exp.pop_front();
        check("a_time", cyc_a, e.cyc);
        if (e.chk) begin
          check("a_i", int'(ia), e.i);
          check("a_q", int'(qa), e.q);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (vc === 1'b1) begin
      if (qc_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL c_extra: valid at cycle %0d want none",
                 cyc_c);
      end else begin
        e = qc_exp.pop_front();
        check("c_time", cyc_c, e.cyc);
        if (e.chk) begin
          check("c_i", int'(ic), e.i);
          check("c_q", int'(qc), e.q);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    if (vb === 1'b1) begin
      b_cnt++;
      b_sum  += int'(ib);
      b_qsum += int'(qb);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_a_i", int'(ia), 0);
    check("rst_a_q", int'(qa), 0);
    check("rst_a_v", int'(va), 0);
    check("rst_b_i", int'(ib), 0);
    check("rst_c_v", int'(vc), 0);

    // Zero input: output every 64 cycles, always zero.
    expect_run(1'b0, 2000, 64, 3, 1, 0, 0);
    ra = 1'b1;
    repeat (2000) @(posedge clk);
    #2;
    check("p1_drain", qa_exp.size(), 0);
    ra = 1'b0;

    // +1/-1: 64^3 >> 8 = 1024 once the transient is flushed.
    repeat (2) @(posedge clk);
    #2;
    ia_in = 6'sd1;
    qa_in = -6'sd1;
    expect_run(1'b0, 600, 64, 3, 4, 1024, -1024);
    ra = 1'b1;
    repeat (600) @(posedge clk);
    #2;
    check("p2_drain", qa_exp.size(), 0);
    ra = 1'b0;

    // Full-scale input with many integrator wraps, stop at cnt=40.
    repeat (2) @(posedge clk);
    #2;
    ia_in = 6'sd31;
    qa_in = -6'sd32;
    expect_run(1'b0, 20008, 64, 3, 4, 31744, -32768);
    ra = 1'b1;
    repeat (20008) @(posedge clk);
    #2;
    check("p3_drain", qa_exp.size(), 0);
    check("p3_hold_i", int'(ia), 31744);
    check("p3_hold_q", int'(qa), -32768);

    // Mid-run reset clears outputs without waiting for a clock.
    ra = 1'b0;
    #1;
    check("p5_async_i", int'(ia), 0);
    check("p5_async_q", int'(qa), 0);
    check("p5_async_v", int'(va), 0);
    repeat (3) @(posedge clk);
    #2;
    expect_run(1'b0, 1000, 64, 3, 4, 31744, -32768);
    ra = 1'b1;
    repeat (1000) @(posedge clk);
    #2;
    check("p5_drain", qa_exp.size(), 0);
    ra = 1'b0;

    // Impulse at full precision. A unit impulse spreads its DC gain
    // R^3 over outputs spaced R inputs apart, so the decimated
    // response sums to R^2 = 4096 whatever the impulse phase.
    rb = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    ib_in = 6'sd1;
    @(posedge clk);
    #2;
    ib_in = 6'sd0;
    repeat (600) @(posedge clk);
    #2;
    check("b_sum", b_sum, 4096);
    check("b_qsum", b_qsum, 0);
    check("b_cnt", b_cnt, 14);
    rb = 1'b0;

    // STAGES=1, R=16: output 5*16 = 80 from the second sample on.
    ic_in = 6'sd5;
    qc_in = -6'sd5;
    expect_run(1'b1, 400, 16, 1, 2, 80, -80);
    rc = 1'b1;
    repeat (400) @(posedge clk);
    #2;
    check("c_drain", qc_exp.size(), 0);
    rc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
